// File: rtl/adc_pulse_sampler.sv
`default_nettype none
// ============================================================================
// Module   : adc_pulse_sampler
// Purpose  : Delays after run rises, then reduces each multi-lane ADC beat to
//            one shifted, saturated signed sample with status flags.
// Revision : 1.0  initial release
// ============================================================================
module adc_pulse_sampler #(
    parameter int NUM_BITS        = 16,
    parameter int ADC_BITS        = 16,
    parameter int SAMPLES_PER_CLK = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [SAMPLES_PER_CLK*ADC_BITS-1:0] adc_tdata,
    input  logic                                adc_tvalid,
    output logic                                adc_tready,
    input  logic                                run,
    input  logic [7:0]                          delay_cycles,
    input  logic [SAMPLES_PER_CLK-1:0]          lane_mask,
    input  logic [2:0]                          avg_shift,
    output logic [NUM_BITS-1:0]                 val_out,
    output logic                                val_valid,
    output logic                                underrun,
    output logic                                sat,
    output logic [15:0]                         out_count
);

    localparam int c_lane_w = ADC_BITS + $clog2(SAMPLES_PER_CLK);
    localparam int c_ext_w  = (c_lane_w > NUM_BITS) ? c_lane_w : NUM_BITS;
    localparam logic signed [c_ext_w-1:0] c_sat_max = c_ext_w'((2**(NUM_BITS-1)) - 1);
    localparam logic signed [c_ext_w-1:0] c_sat_min = ~c_sat_max;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

    state_t                       r_state;
    state_t                       w_state_nxt;
    logic                         r_run_q;
    logic [7:0]                   r_cnt;
    logic [SAMPLES_PER_CLK-1:0]   r_mask;
    logic [2:0]                   r_shift;
    logic                         r_s1_valid;
    logic signed [c_lane_w-1:0]   r_lane    [SAMPLES_PER_CLK];
    logic signed [c_lane_w-1:0]   w_lane_in [SAMPLES_PER_CLK];
    logic signed [c_lane_w-1:0]   w_sum;
    logic signed [c_lane_w-1:0]   w_shifted;
    logic signed [c_ext_w-1:0]    w_ext;
    logic                         w_clip_hi;
    logic                         w_clip_lo;
    logic [NUM_BITS-1:0]          w_sat_val;
    logic                         w_rise;
    logic                         w_accept;
    logic                         w_bubble;
    logic                         w_emit;

    assign adc_tready = 1'b1;
    assign w_rise     = run & ~r_run_q;
    assign w_accept   = run & (r_state == ST_STREAM) & adc_tvalid;
    assign w_bubble   = run & (r_state == ST_STREAM) & ~adc_tvalid;
    // Dropping run kills whatever is still in the pipe on the same edge.
    assign w_emit     = run & r_s1_valid;

    always_comb begin
        w_state_nxt = r_state;
        if (!run) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:   if (w_rise) w_state_nxt = (delay_cycles == 8'd0) ? ST_STREAM : ST_DELAY;
                ST_DELAY:  if (r_cnt == 8'd1) w_state_nxt = ST_STREAM;
                ST_STREAM: w_state_nxt = ST_STREAM;
                default:   w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Lane extraction: sign-extend to the sum width, masked by the shadow mask.
    for (genvar gi = 0; gi < SAMPLES_PER_CLK; gi++) begin : g_lane
        logic signed [ADC_BITS-1:0] w_raw;
        logic signed [c_lane_w-1:0] w_sx;
        assign w_raw         = adc_tdata[gi*ADC_BITS +: ADC_BITS];
        assign w_sx          = w_raw;
        assign w_lane_in[gi] = r_mask[gi] ? w_sx : '0;
    end

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < SAMPLES_PER_CLK; i++) begin
            w_sum = w_sum + r_lane[i];
        end
    end

    assign w_shifted = w_sum >>> r_shift;
    assign w_ext     = w_shifted;
    assign w_clip_hi = (w_ext > c_sat_max);
    assign w_clip_lo = (w_ext < c_sat_min);
    assign w_sat_val = w_clip_hi ? c_sat_max[NUM_BITS-1:0] :
                       w_clip_lo ? c_sat_min[NUM_BITS-1:0] : w_ext[NUM_BITS-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_run_q    <= 1'b0;
            r_cnt      <= 8'd0;
            r_mask     <= '0;
            r_shift    <= 3'd0;
            r_s1_valid <= 1'b0;
            val_out    <= '0;
            val_valid  <= 1'b0;
            underrun   <= 1'b0;
            sat        <= 1'b0;
            out_count  <= 16'd0;
        end else begin
            r_run_q    <= run;
            r_s1_valid <= w_accept;
            val_valid  <= w_emit;
            if (r_state == ST_IDLE && w_rise) begin
                r_cnt     <= delay_cycles;
                r_mask    <= lane_mask;
                r_shift   <= avg_shift;
                underrun  <= 1'b0;
                sat       <= 1'b0;
                out_count <= 16'd0;
            end else begin
                if (r_state == ST_DELAY) r_cnt <= r_cnt - 8'd1;
                if (w_bubble) underrun <= 1'b1;
                if (w_emit) begin
                    val_out <= w_sat_val;
                    if (w_clip_hi || w_clip_lo) sat <= 1'b1;
                    if (out_count != 16'hFFFF) out_count <= out_count + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SAMPLES_PER_CLK; i++) r_lane[i] <= '0;
        end else if (w_accept) begin
            for (int i = 0; i < SAMPLES_PER_CLK; i++) r_lane[i] <= w_lane_in[i];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_adc_pulse_sampler.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_pulse_sampler
// Purpose  : Directed self-checking bench for adc_pulse_sampler.
// Revision : 1.0  initial release
// ============================================================================
module tb_adc_pulse_sampler;

    localparam int SPC = 8;
    localparam int AB  = 16;

    logic            clk;
    logic            rst;
    logic [SPC*AB-1:0] adc_tdata;
    logic            adc_tvalid;
    logic            adc_tready;
    logic            run;
    logic [7:0]      delay_cycles;
    logic [SPC-1:0]  lane_mask;
    logic [2:0]      avg_shift;
    logic [15:0]     val_out;
    logic            val_valid;
    logic            underrun;
    logic            sat;
    logic [15:0]     out_count;

    int n_cmp = 0;
    int n_err = 0;

    adc_pulse_sampler #(.NUM_BITS(16), .ADC_BITS(AB), .SAMPLES_PER_CLK(SPC)) dut (
        .clk          (clk),
        .rst          (rst),
        .adc_tdata    (adc_tdata),
        .adc_tvalid   (adc_tvalid),
        .adc_tready   (adc_tready),
        .run          (run),
        .delay_cycles (delay_cycles),
        .lane_mask    (lane_mask),
        .avg_shift    (avg_shift),
        .val_out      (val_out),
        .val_valid    (val_valid),
        .underrun     (underrun),
        .sat          (sat),
        .out_count    (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [SPC*AB-1:0] mk(input logic [15:0] l0, input logic [15:0] rest);
        mk = {{(SPC-1){rest}}, l0};
    endfunction

    // One zero-delay run with identical lanes; output is checked 3 cycles after the rise.
    task automatic do_run(input string tag, input logic [15:0] lane, input logic [7:0] mask,
                          input logic [2:0] shift, input logic [15:0] exp_out, input logic exp_sat);
        run = 1'b0;
        tick();
        adc_tdata    = {SPC{lane}};
        lane_mask    = mask;
        avg_shift    = shift;
        delay_cycles = 8'd0;
        adc_tvalid   = 1'b1;
        run          = 1'b1;
        tick();
        tick();
        tick();
        chk({tag, " valid"}, val_valid, 1);
        chk({tag, " val_out"}, val_out, exp_out);
        chk({tag, " sat"}, sat, exp_sat);
        run = 1'b0;
        tick();
    endtask

    initial begin
        logic [15:0] exp_last;
        logic        exp_v;

        rst          = 1'b0;
        run          = 1'b0;
        adc_tdata    = '0;
        adc_tvalid   = 1'b0;
        delay_cycles = 8'd0;
        lane_mask    = '0;
        avg_shift    = 3'd0;
        tick();
        tick();
        chk("reset tready", adc_tready, 1);
        chk("reset val_out", val_out, 0);
        chk("reset val_valid", val_valid, 0);
        chk("reset underrun", underrun, 0);
        chk("reset sat", sat, 0);
        chk("reset out_count", out_count, 0);
        rst = 1'b1;
        tick();

        // Ramp with delay 3: run rises in cycle 0, first output in cycle 6.
        delay_cycles = 8'd3;
        lane_mask    = 8'h01;
        avg_shift    = 3'd0;
        adc_tvalid   = 1'b1;
        adc_tdata    = mk(16'd0, 16'h0100);
        run          = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            tick();
            chk($sformatf("ramp valid c%0d", c), val_valid, (c >= 6) ? 1 : 0);
            if (c >= 6) chk($sformatf("ramp val_out c%0d", c), val_out, c - 2);
            adc_tdata = mk(16'(c), 16'h0100);
        end
        chk("ramp out_count", out_count, 4);
        run = 1'b0;
        tick();
        chk("ramp drop valid", val_valid, 0);
        chk("ramp drop count", out_count, 4);

        do_run("sat_pos", 16'h7FFF, 8'hFF, 3'd0, 16'h7FFF, 1'b1);
        do_run("sat_neg", 16'h8000, 8'hFF, 3'd0, 16'h8000, 1'b1);
        do_run("avg1000", 16'd1000, 8'hFF, 3'd3, 16'd1000, 1'b0);
        do_run("neg_floor", 16'hFFFD, 8'h03, 3'd1, 16'hFFFD, 1'b0);
        do_run("mask0", 16'h1234, 8'h00, 3'd0, 16'h0000, 1'b0);

        // Underrun: delay 0, tvalid low in cycles 4 and 5.
        run          = 1'b0;
        tick();
        delay_cycles = 8'd0;
        lane_mask    = 8'h01;
        avg_shift    = 3'd0;
        adc_tvalid   = 1'b1;
        adc_tdata    = mk(16'd0, 16'h0100);
        run          = 1'b1;
        exp_last     = 16'd0;
        for (int c = 1; c <= 9; c++) begin
            tick();
            exp_v = (c - 2 >= 1) && (c - 2 != 4) && (c - 2 != 5);
            if (exp_v) exp_last = 16'(c - 2);
            chk($sformatf("urun valid c%0d", c), val_valid, exp_v);
            if (c >= 3) chk($sformatf("urun val_out c%0d", c), val_out, exp_last);
            adc_tvalid = (c != 4) && (c != 5);
            adc_tdata  = mk(16'(c), 16'h0100);
        end
        chk("urun underrun", underrun, 1);
        chk("urun out_count", out_count, 5);
        run = 1'b0;
        tick();
        chk("urun drop valid", val_valid, 0);
        chk("urun drop underrun", underrun, 1);
        chk("urun drop count", out_count, 5);
        adc_tvalid = 1'b1;
        run        = 1'b1;
        tick();
        chk("rerise underrun", underrun, 0);
        chk("rerise count", out_count, 0);
        tick();
        tick();
        tick();
        chk("rerise valid", val_valid, 1);

        // Asynchronous reset in the middle of a cycle while streaming.
        #2;
        rst = 1'b0;
        #1;
        chk("async valid", val_valid, 0);
        chk("async count", out_count, 0);
        chk("async val_out", val_out, 0);
        run = 1'b0;
        tick();
        rst = 1'b1;
        tick();

        // Mid-run mask change is ignored until the next rise.
        delay_cycles = 8'd0;
        lane_mask    = 8'h01;
        avg_shift    = 3'd0;
        adc_tvalid   = 1'b1;
        adc_tdata    = {{(SPC-2){16'h0100}}, 16'h0022, 16'h0011};
        run          = 1'b1;
        tick();
        tick();
        tick();
        chk("mask lane0 a", val_out, 16'h0011);
        lane_mask = 8'h02;
        tick();
        tick();
        chk("mask lane0 b", val_out, 16'h0011);
        chk("mask lane0 valid", val_valid, 1);
        run = 1'b0;
        tick();
        run = 1'b1;
        tick();
        tick();
        tick();
        chk("mask lane1", val_out, 16'h0022);
        chk("mask lane1 valid", val_valid, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adc_pulse_sampler.md
Name: adc_pulse_sampler

Overview:
- Upstream neighbour of the experiment FSM's ADC inputs; one instance each drives the MAC path (mac_val_in/mac_val_valid, gated by mac_run) and the NL path (nl_val_in/nl_val_valid, gated by nl_run).
- Takes the wide multi-sample ADC AXI-stream and waits a programmable number of clk cycles after run rises, to align with optical path delay.
- Then emits one reduced sample per beat: the signed sum of selected lanes, arithmetic-shifted and saturated to num_bits.
- Provides sticky underrun and saturation flags and a count of emitted samples for CPU readback.

Parameters:
NUM_BITS, 16, output sample width (matches ising_config num_bits)
ADC_BITS, 16, signed width of one ADC lane
SAMPLES_PER_CLK, 8, lanes per ADC beat (power of 2)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
adc_tdata  input  SAMPLES_PER_CLK*ADC_BITS  ADC beat; lane i = bits [i*ADC_BITS +: ADC_BITS], lane 0 earliest
adc_tvalid  input  1  beat valid
adc_tready  output  1  always 1 (ADC cannot stall)
run  input  1  mac_run / nl_run from experiment FSM
delay_cycles  input  8  cycles to discard after run rises
lane_mask  input  SAMPLES_PER_CLK  lanes included in sum
avg_shift  input  3  arithmetic right shift applied to sum
val_out  output  NUM_BITS  reduced signed sample
val_valid  output  1  val_out valid this cycle
underrun  output  1  sticky: adc_tvalid low during STREAM
sat  output  1  sticky: saturation occurred
out_count  output  16  valid outputs since last run rise, saturates at 16'hFFFF

Behaviour:
- Reset: val_out=0, val_valid=0, underrun=0, sat=0, out_count=0, state IDLE, all pipeline valids 0. adc_tready=1 at all times, including reset.
- States:
  - IDLE: run_q tracks run. On rising edge of run:
    - latch delay_cycles, lane_mask, avg_shift into shadow registers;
    - clear underrun, sat, out_count;
    - go to DELAY with counter = delay_cycles, or directly to STREAM if delay_cycles=0.
  - DELAY: decrement the counter each clk, independent of adc_tvalid; ADC beats are discarded. At counter==1, go to STREAM on the next edge. Exactly delay_cycles cycles are spent in DELAY.
  - STREAM: each cycle with adc_tvalid=1, the beat enters the pipeline. A cycle with adc_tvalid=0 inserts a bubble and sets underrun.
  - Any state: run=0 sampled at a clk edge -> IDLE on that edge, pipeline valids cleared the same edge, so val_valid=0 on the following cycle. In-flight data is dropped. Flags and out_count hold their values until the next run rise.
- Shadow configs are used throughout a run; input changes mid-run are ignored.
- Pipeline, 2-cycle latency from the accepting edge to val_valid=1:
  - S1: register each lane sign-extended to ADC_BITS+log2(SAMPLES_PER_CLK) bits, zeroed where lane_mask=0.
  - S2: signed sum of all S1 lanes; arithmetic shift right by avg_shift (floor toward -inf); saturate to NUM_BITS signed range [-2^(NUM_BITS-1), 2^(NUM_BITS-1)-1].
    - If clipped, set sat.
    - Register into val_out; set val_valid.
    - Increment out_count (saturating).
- val_out holds its last value when val_valid=0.
- lane_mask=0 produces valid zeros.
- A run rise on the same edge as run going low is impossible (single bit). A re-rise while the pipeline is still flushing re-latches configs. Flushed data never appears.
- Reset mid-operation: immediate return to reset values, asynchronously.

Test Plan:
- Reset with run=0: all outputs at reset values, adc_tready=1. Assert/deassert rst mid-STREAM -> val_valid drops to 0 asynchronously, out_count=0.
- Config delay_cycles=3, lane_mask=8'h01, avg_shift=0. Raise run at cycle 0 with a continuous valid ramp, lane0 = cycle index. Required:
  - beats at cycles 1..3 discarded;
  - first val_valid at cycle 6 with val_out=4;
  - consecutive outputs 5, 6, ….
- All lanes = 1000, lane_mask=8'hFF, avg_shift=3 -> val_out=1000. All lanes = -3, mask=8'h03, shift=1 -> val_out=-3 (floor of -6/2).
- All lanes = 16'h7FFF, mask=8'hFF, shift=0 -> val_out=16'h7FFF, sat=1. All lanes = 16'h8000 -> val_out=16'h8000, sat=1.
- delay_cycles=0, adc_tvalid low for 2 cycles mid-stream -> two-cycle val_valid gap 2 cycles later, underrun=1, out_count excludes the gap. Drop run -> val_valid=0 next cycle, underrun and out_count held. Raise run again -> both cleared.
- Change lane_mask from 8'h01 to 8'h02 mid-run -> output still lane0 until run is re-raised, then lane1.
